// File: rtl/instruction_fetch.sv
// Fetch/issue stage: loadable instruction memory, program counter and run FSM,
// with a two-entry write scoreboard that inserts bubbles on read-after-write hazards.
module instruction_fetch #(
    parameter int          AW           = 5,
    parameter logic [16:0] NOP          = 17'h00000,
    parameter logic [3:0]  WE_MASK      = 4'b0001,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          LOAD_EN,
    input  logic [AW-1:0] LOAD_ADDR,
    input  logic [16:0]   LOAD_DATA,
    input  logic          START,
    input  logic [AW:0]   PROG_LEN,
    output logic [16:0]   INST,
    output logic          INST_VALID,
    output logic [AW-1:0] PC,
    output logic          BUSY,
    output logic          DONE,
    output logic [15:0]   STALL_CNT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int          DEPTH     = 1 << AW;
    localparam logic [AW:0] DEPTH_LEN = (AW + 1)'(DEPTH);
    localparam int          DW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    logic [16:0]   mem [DEPTH];

    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [AW:0]   len_reg, len_next;
    logic [16:0]   inst_reg, inst_next;
    logic          valid_reg, valid_next;
    logic [15:0]   stall_reg, stall_next;
    logic [DW-1:0] drain_reg, drain_next;
    logic          s0_v_reg, s0_v_next, s1_v_reg, s1_v_next;
    logic [4:0]    s0_wa_reg, s0_wa_next, s1_wa_reg, s1_wa_next;

    logic [16:0]   cand;
    logic          hazard;
    logic          issue;
    logic          load_ok;

    assign load_ok = (state_reg == S_IDLE) || (state_reg == S_DONE);

    // Memory survives reset; writes are locked out while a program is running.
    always_ff @(posedge CLK) begin
        if (LOAD_EN && load_ok) begin
            mem[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    assign cand   = mem[pc_reg];
    assign hazard = (s0_v_reg && ((s0_wa_reg == cand[9:5]) || (s0_wa_reg == cand[4:0]))) ||
                    (s1_v_reg && ((s1_wa_reg == cand[9:5]) || (s1_wa_reg == cand[4:0])));
    assign issue  = (state_reg == S_RUN) && !hazard;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        len_next   = len_reg;
        inst_next  = NOP;
        valid_next = 1'b0;
        stall_next = stall_reg;
        drain_next = drain_reg;
        // Scoreboard shifts every cycle; bubbles push an invalid entry.
        s1_v_next  = s0_v_reg;
        s1_wa_next = s0_wa_reg;
        s0_v_next  = WE_MASK[cand[16:15]] & issue;
        s0_wa_next = cand[14:10];

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (START) begin
                    stall_next = 16'd0;
                    s0_v_next  = 1'b0;
                    s1_v_next  = 1'b0;
                    if (PROG_LEN == '0) begin
                        state_next = S_DONE;
                    end else begin
                        len_next   = (PROG_LEN > DEPTH_LEN) ? DEPTH_LEN : PROG_LEN;
                        pc_next    = '0;
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (hazard) begin
                    if (stall_reg != 16'hFFFF) begin
                        stall_next = stall_reg + 16'd1;
                    end
                end else begin
                    inst_next  = cand;
                    valid_next = 1'b1;
                    pc_next    = pc_reg + AW'(1);
                    // A full-depth program wraps PC to 0 here; shorter ones stop at len.
                    if ({1'b0, pc_reg} == len_reg - (AW + 1)'(1)) begin
                        state_next = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                        drain_next = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    state_next = S_DONE;
                end else begin
                    drain_next = drain_reg + DW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= S_IDLE;
            pc_reg    <= '0;
            len_reg   <= '0;
            inst_reg  <= NOP;
            valid_reg <= 1'b0;
            stall_reg <= 16'd0;
            drain_reg <= '0;
            s0_v_reg  <= 1'b0;
            s0_wa_reg <= '0;
            s1_v_reg  <= 1'b0;
            s1_wa_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            len_reg   <= len_next;
            inst_reg  <= inst_next;
            valid_reg <= valid_next;
            stall_reg <= stall_next;
            drain_reg <= drain_next;
            s0_v_reg  <= s0_v_next;
            s0_wa_reg <= s0_wa_next;
            s1_v_reg  <= s1_v_next;
            s1_wa_reg <= s1_wa_next;
        end
    end

    assign INST       = inst_reg;
    assign INST_VALID = valid_reg;
    assign PC         = pc_reg;
    assign BUSY       = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign DONE       = (state_reg == S_DONE);
    assign STALL_CNT  = stall_reg;

endmodule
